// File: rtl/io_uart.sv
// io_uart: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Register reads are combinational; the MMU supplies the read pipeline stage.
module io_uart #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        uart_tx
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  localparam logic [5:0] REG_TXDATA  = 6'h00;
  localparam logic [5:0] REG_STATUS  = 6'h01;
  localparam logic [5:0] REG_BAUDDIV = 6'h02;
  localparam logic [5:0] REG_COUNT   = 6'h03;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [15:0]      div_q, div_d;
  logic             tx_q, tx_d;
  logic [15:0]      bauddiv_q, bauddiv_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic [5:0] sel;
  logic       wr_acc, wr_tx, wr_stat, wr_baud;
  logic       fifo_empty, fifo_full;
  logic       push, pop, drop, load, bit_end;
  logic       unused_bits;

  assign sel        = io_addr[7:2];
  assign wr_acc     = io_en & io_we;
  assign wr_tx      = wr_acc && (sel == REG_TXDATA);
  assign wr_stat    = wr_acc && (sel == REG_STATUS);
  assign wr_baud    = wr_acc && (sel == REG_BAUDDIV);
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign bit_end    = (clk_cnt_q == div_q);
  assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

  // A full FIFO still accepts a byte on the cycle the FSM pops its head.
  assign push = wr_tx && (!fifo_full || pop);
  assign drop = wr_tx && fifo_full && !pop;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    div_d     = div_q;
    load      = 1'b0;
    pop       = 1'b0;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_d = '0;
          if (!fifo_empty) load = 1'b1;
          else state_d = IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Frame start: divisor is frozen here so BAUDDIV writes only hit later frames.
    if (load) begin
      pop       = 1'b1;
      shift_d   = mem_q[rd_ptr_q];
      div_d     = bauddiv_q;
      clk_cnt_d = '0;
      state_d   = START;
    end
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d     = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    bauddiv_d = wr_baud ? io_data_write[15:0] : bauddiv_q;
    ovf_d     = ovf_q;
    if (wr_stat && io_data_write[3]) ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      bauddiv_q <= DEFAULT_DIV;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      bauddiv_q <= bauddiv_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= io_data_write[7:0];
    shift_q <= shift_d;
    div_q   <= div_d;
  end

  assign uart_tx = tx_q;

  // While reset is held, reads show the state the block is about to take.
  logic             v_empty, v_full, v_busy, v_ovf;
  logic [15:0]      v_baud;
  logic [CNT_W-1:0] v_cnt;

  assign v_empty = !resetb || fifo_empty;
  assign v_full  = resetb && fifo_full;
  assign v_busy  = resetb && (state_q != IDLE);
  assign v_ovf   = resetb && ovf_q;
  assign v_baud  = resetb ? bauddiv_q : DEFAULT_DIV;
  assign v_cnt   = resetb ? cnt_q : '0;

  always_comb begin
    io_data_read = '0;
    if (io_en) begin
      case (sel)
        REG_STATUS:  io_data_read = {28'd0, v_ovf, v_busy, v_full, v_empty};
        REG_BAUDDIV: io_data_read = {16'd0, v_baud};
        REG_COUNT:   io_data_read = 32'(v_cnt);
        default:     io_data_read = '0;
      endcase
    end
  end
endmodule
